async_multi_param: RTL and testbench
====================================

// Module: async_multi_param
// PURPOSE
//  Parametrised multi-byte UART transmitter; next generation of the fixed 8-byte async_multi.
//  Serialises 1..MAX_BYTES bytes from a packed word onto TxD, back-to-back.
//  Frame timing, parity and stop bits are set by parameters.
//  Sits between packet/telemetry logic and the board UART pin; the TxD_start/busy handshake is unchanged.
// PARAMETERS
//  CLK_FREQ   100_000_000  clk frequency, Hz
//  BAUD       115_200      bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 2)
//  MAX_BYTES  8            max bytes per transfer (1..16)
//  PARITY     0            0 = none, 1 = even, 2 = odd
//  STOP_BITS  1            1 or 2
//  GAP_BITS   0            idle-high bit periods inserted between bytes (0..15), not after last byte
// PORTS
//  clk        in   1                       system clock
//  rst        in   1                       synchronous, active-high reset
//  TxD_start  in   1                       request; sampled only while busy==0
//  TxD_bytes  in   $clog2(MAX_BYTES+1)     byte count, latched with start
//  TxD_data   in   8*MAX_BYTES             payload; byte k = TxD_data[8k+7:8k], latched with start
//  TxD        out  1                       serial line, idle high (registered)
//  busy       out  1                       transfer in progress (registered)
//  done       out  1                       1-cycle pulse at end of transfer (registered)
// BEHAVIOUR
//  Reset: on any edge with rst=1 -> TxD=1, busy=0, done=0, state IDLE, all counters 0.
//   Reset takes priority mid-frame: the line returns high on that edge and the frame is abandoned.
//  Accept: edge E0 with busy=0, TxD_start=1, TxD_bytes!=0.
//   On E0: latch data; latch n = min(TxD_bytes, MAX_BYTES); busy<=1; TxD<=0 (start bit).
//   TxD_bytes==0 -> request ignored; no busy, no done.
//   TxD_start while busy=1 -> ignored; the latched data/count are unaffected.
//  Bit timer: every line state (start/data/parity/stop/gap bit) is held for exactly CLKS_PER_BIT cycles.
//  FSM: IDLE -> START -> DATA(x8) -> [PARITY if PARITY!=0] -> STOP(xSTOP_BITS)
//   -> [GAP(xGAP_BITS) if more bytes] -> START (next byte) | IDLE (last byte).
//  Ordering and bit values:
//   - bytes sent in order k=0..n-1; bits within a byte LSB first.
//   - parity bit = ^byte for even parity; ~^byte for odd.
//   - stop and gap bits drive TxD=1.
//  Frame length: F = 1 + 8 + (PARITY!=0) + STOP_BITS.
//   Total busy length = CLKS_PER_BIT*(n*F + (n-1)*GAP_BITS) cycles.
//  End of transfer (edge where the last stop-bit period expires):
//   busy<=0, done<=1 (cleared next edge), TxD stays 1.
//   A new start may be sampled on the following edge (zero-gap restart allowed).
//  Byte index and bit counters are sized for MAX_BYTES and 8 bits; they never wrap inside a transfer.
// TESTING (bench: CLK_FREQ=100e6, BAUD=10e6 -> 10 clk/bit, 10 ns clk)
//  1 Defaults (no parity, 1 stop): bytes=8, data=64'hAAFF0055AAFF0055, 1-cycle start ->
//    busy high 800 cycles, done pulse once.
//    First frame on TxD: 0,1,0,1,0,1,0,1,0,1 (byte 0x55); second frame carries 0x00.
//  2 PARITY=1 then PARITY=2, bytes=1, data[7:0]=8'hA5 ->
//    11-bit frame, parity bit 0 (even) / 1 (odd), busy 110 cycles.
//  3 STOP_BITS=2, GAP_BITS=3, bytes=2 -> 2 stop periods per byte, 30 cycles idle between bytes,
//    none after the last byte; busy = 10*(2*11+3) = 250 cycles.
//  4 bytes=0 with start -> TxD stays 1, busy/done never assert.
//    bytes=12 (MAX_BYTES=8) -> exactly 8 frames sent.
//  5 start pulse re-asserted with new data at cycle 300 of transfer 1 -> ignored,
//    original bytes sent; start in the cycle after done -> new transfer begins immediately.
//  6 rst=1 for 1 cycle at cycle 45 of a transfer -> TxD=1, busy=0, done=0 on that edge;
//    no done pulse afterwards; next start works normally.

Source files
------------

// File: rtl/async_multi_param.sv
// Parametrised multi-byte UART transmitter: sends 1..MAX_BYTES bytes back-to-back
// with configurable parity, stop bits and inter-byte idle gap.
module async_multi_param #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int MAX_BYTES = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           TxD_start,
    input  logic [$clog2(MAX_BYTES+1)-1:0] TxD_bytes,
    input  logic [8*MAX_BYTES-1:0]         TxD_data,
    output logic                           TxD,
    output logic                           busy,
    output logic                           done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BYTES_W      = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0]   TIMER_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [3:0]         GAP_LAST   = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [BYTES_W-1:0] BYTES_MAX  = BYTES_W'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP,
        GAP
    } StateType;

    StateType               state, stateNext;
    logic [CNT_W-1:0]       bitTimer, bitTimerNext;
    logic [3:0]             bitCnt, bitCntNext;
    logic [BYTES_W-1:0]     bytesLeft, bytesLeftNext;
    logic [8*MAX_BYTES-1:0] shiftData, shiftDataNext;
    logic                   txdNext, busyNext, doneNext;

    logic       bitTick;
    logic [7:0] curByte;
    logic       parityBit;

    assign bitTick   = (bitTimer == TIMER_LAST);
    assign curByte   = shiftData[7:0];
    assign parityBit = (PARITY == 2) ? ~(^curByte) : (^curByte);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bitTimer  <= '0;
            bitCnt    <= '0;
            bytesLeft <= '0;
            shiftData <= '0;
            TxD       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= stateNext;
            bitTimer  <= bitTimerNext;
            bitCnt    <= bitCntNext;
            bytesLeft <= bytesLeftNext;
            shiftData <= shiftDataNext;
            TxD       <= txdNext;
            busy      <= busyNext;
            done      <= doneNext;
        end
    end

    // Every line state lasts one full bit period; all transitions happen on bitTick
    // and drive the next line level so TxD stays a clean registered output.
    always_comb begin
        stateNext     = state;
        bitTimerNext  = bitTimer;
        bitCntNext    = bitCnt;
        bytesLeftNext = bytesLeft;
        shiftDataNext = shiftData;
        txdNext       = TxD;
        busyNext      = busy;
        doneNext      = 1'b0;

        if (state != IDLE) begin
            bitTimerNext = bitTick ? '0 : bitTimer + 1'b1;
        end

        case (state)
            IDLE: begin
                txdNext = 1'b1;
                if (TxD_start && (TxD_bytes != '0)) begin
                    stateNext     = START;
                    shiftDataNext = TxD_data;
                    bytesLeftNext = (TxD_bytes > BYTES_MAX) ? BYTES_MAX : TxD_bytes;
                    bitTimerNext  = '0;
                    bitCntNext    = '0;
                    busyNext      = 1'b1;
                    txdNext       = 1'b0;
                end
            end
            START: begin
                if (bitTick) begin
                    stateNext  = DATA;
                    bitCntNext = '0;
                    txdNext    = curByte[0];
                end
            end
            DATA: begin
                if (bitTick) begin
                    if (bitCnt == 4'd7) begin
                        bitCntNext = '0;
                        if (PARITY != 0) begin
                            stateNext = PARITY_BIT;
                            txdNext   = parityBit;
                        end else begin
                            stateNext = STOP;
                            txdNext   = 1'b1;
                        end
                    end else begin
                        bitCntNext = bitCnt + 1'b1;
                        txdNext    = curByte[3'(bitCnt + 1'b1)];
                    end
                end
            end
            PARITY_BIT: begin
                if (bitTick) begin
                    stateNext  = STOP;
                    bitCntNext = '0;
                    txdNext    = 1'b1;
                end
            end
            STOP: begin
                if (bitTick) begin
                    if (bitCnt == STOP_LAST) begin
                        bitCntNext = '0;
                        if (bytesLeft == BYTES_W'(1)) begin
                            stateNext     = IDLE;
                            bytesLeftNext = '0;
                            busyNext      = 1'b0;
                            doneNext      = 1'b1;
                            txdNext       = 1'b1;
                        end else if (GAP_BITS > 0) begin
                            stateNext = GAP;
                            txdNext   = 1'b1;
                        end else begin
                            stateNext     = START;
                            bytesLeftNext = bytesLeft - 1'b1;
                            shiftDataNext = shiftData >> 8;
                            txdNext       = 1'b0;
                        end
                    end else begin
                        bitCntNext = bitCnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (bitTick) begin
                    if (bitCnt == GAP_LAST) begin
                        stateNext     = START;
                        bitCntNext    = '0;
                        bytesLeftNext = bytesLeft - 1'b1;
                        shiftDataNext = shiftData >> 8;
                        txdNext       = 1'b0;
                    end else begin
                        bitCntNext = bitCnt + 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
                txdNext   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_async_multi_param.sv
// Self-checking bench for async_multi_param: four parameter variants, a vector table,
// hand-written corner sequences and randomized transfers against a bit-list model.
module tb_async_multi_param;

    localparam int CPB  = 10;
    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  startV;
    logic [3:0]  txBytes;
    logic [63:0] txData;
    wire  [3:0]  txdV;
    wire  [3:0]  busyV;
    wire  [3:0]  doneV;

    always #5 clk = ~clk;

    int parOf  [NDUT] = '{0, 1, 2, 0};
    int stopOf [NDUT] = '{1, 1, 1, 2};
    int gapOf  [NDUT] = '{0, 0, 0, 3};

    async_multi_param #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .MAX_BYTES(8),
                        .PARITY(0), .STOP_BITS(1), .GAP_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .TxD_start(startV[0]), .TxD_bytes(txBytes),
        .TxD_data(txData), .TxD(txdV[0]), .busy(busyV[0]), .done(doneV[0]));

    async_multi_param #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .MAX_BYTES(8),
                        .PARITY(1), .STOP_BITS(1), .GAP_BITS(0)) dut1 (
        .clk(clk), .rst(rst), .TxD_start(startV[1]), .TxD_bytes(txBytes),
        .TxD_data(txData), .TxD(txdV[1]), .busy(busyV[1]), .done(doneV[1]));

    async_multi_param #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .MAX_BYTES(8),
                        .PARITY(2), .STOP_BITS(1), .GAP_BITS(0)) dut2 (
        .clk(clk), .rst(rst), .TxD_start(startV[2]), .TxD_bytes(txBytes),
        .TxD_data(txData), .TxD(txdV[2]), .busy(busyV[2]), .done(doneV[2]));

    async_multi_param #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .MAX_BYTES(8),
                        .PARITY(0), .STOP_BITS(2), .GAP_BITS(3)) dut3 (
        .clk(clk), .rst(rst), .TxD_start(startV[3]), .TxD_bytes(txBytes),
        .TxD_data(txData), .TxD(txdV[3]), .busy(busyV[3]), .done(doneV[3]));

    typedef struct {
        int          dut;
        logic [63:0] data;
        int          bytes;
        int          busyLen;
        int          parityBit;
    } VecT;

    VecT  vecs [8];
    int   checks = 0;
    int   passes = 0;
    logic expWave [$];
    logic capWave [$];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Expected line level per clock: list the frame bits, then stretch each to CPB cycles.
    task automatic buildModel(input int idx, input logic [63:0] data, input int bytes);
        int         n;
        logic [7:0] b;
        logic       bits [$];
        n = (bytes > 8) ? 8 : bytes;
        expWave.delete();
        for (int k = 0; k < n; k++) begin
            b = data[8*k +: 8];
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(b[i]);
            if (parOf[idx] == 1) bits.push_back(^b);
            else if (parOf[idx] == 2) bits.push_back(~(^b));
            for (int s = 0; s < stopOf[idx]; s++) bits.push_back(1'b1);
            if (k < n - 1)
                for (int g = 0; g < gapOf[idx]; g++) bits.push_back(1'b1);
        end
        foreach (bits[j]) repeat (CPB) expWave.push_back(bits[j]);
    endtask

    task automatic applyStimulus(input int idx, input logic [63:0] data, input int bytes);
        txData      = data;
        txBytes     = 4'(bytes);
        startV[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startV[idx] = 1'b0;
    endtask

    task automatic observe(input int idx, input int pokeAt, input logic [63:0] pokeData,
                           output int txdErr, output int busyErr, output int doneErr,
                           output int busyCycles);
        int L;
        L = expWave.size();
        txdErr = 0; busyErr = 0; doneErr = 0; busyCycles = 0;
        capWave.delete();
        for (int k = 0; k <= L; k++) begin
            if (k > 0) @(negedge clk);
            if (k == pokeAt + 1) startV[idx] = 1'b0;
            capWave.push_back(txdV[idx]);
            if (txdV[idx] !== ((k < L) ? expWave[k] : 1'b1)) txdErr++;
            if (busyV[idx] !== (k < L)) busyErr++;
            if (doneV[idx] !== (k == L)) doneErr++;
            if (busyV[idx] === 1'b1) busyCycles++;
            if (k == pokeAt) begin
                txData      = pokeData;
                txBytes     = 4'd3;
                startV[idx] = 1'b1;
            end
        end
    endtask

    task automatic checkRun(input string name, input int busyLen, input int txdErr,
                            input int busyErr, input int doneErr, input int busyCycles);
        checkOutput({name, "_txdWave"}, txdErr, 0);
        checkOutput({name, "_busyLen"}, busyCycles, busyLen);
        checkOutput({name, "_busyShape"}, busyErr, 0);
        checkOutput({name, "_donePulse"}, doneErr, 0);
    endtask

    task automatic settle(input int idx, input string name);
        @(negedge clk);
        checkOutput({name, "_doneClr"}, doneV[idx], 0);
        checkOutput({name, "_idleHigh"}, txdV[idx], 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic runVector(input string name, input VecT v);
        int te, be, de, bc;
        buildModel(v.dut, v.data, v.bytes);
        applyStimulus(v.dut, v.data, v.bytes);
        observe(v.dut, -1, 64'h0, te, be, de, bc);
        checkRun(name, v.busyLen, te, be, de, bc);
        if (v.parityBit >= 0)
            checkOutput({name, "_parityBit"}, capWave[9*CPB + CPB/2], v.parityBit);
        settle(v.dut, name);
    endtask

    initial begin
        int          te, be, de, bc, bad, idx, bytes;
        logic [9:0]  frame;
        logic [63:0] data;

        vecs[0] = '{0, 64'hAAFF0055AAFF0055, 8, 800, -1};
        vecs[1] = '{1, 64'h00000000000000A5, 1, 110, 0};
        vecs[2] = '{2, 64'h00000000000000A5, 1, 110, 1};
        vecs[3] = '{3, 64'h00000000000081C3, 2, 250, -1};
        vecs[4] = '{0, 64'h0123456789ABCDEF, 12, 800, -1};
        vecs[5] = '{0, 64'h000000000000003C, 1, 100, -1};
        vecs[6] = '{3, 64'h00000000000000E7, 1, 110, -1};
        vecs[7] = '{1, 64'h0000000000C35A01, 3, 330, 1};

        rst = 1'b1; startV = '0; txBytes = '0; txData = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_txd", txdV, 4'hF);
        checkOutput("reset_busy", busyV, 0);
        checkOutput("reset_done", doneV, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
            if (i == 0) begin
                for (int j = 0; j < 10; j++) frame[j] = capWave[j*CPB + CPB/2];
                checkOutput("vec0_frame0", frame, 10'h2AA);
                for (int j = 0; j < 10; j++) frame[j] = capWave[(10 + j)*CPB + CPB/2];
                checkOutput("vec0_frame1", frame, 10'h200);
            end
        end

        // Zero byte count must be ignored entirely.
        applyStimulus(0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (busyV[0] !== 1'b0 || doneV[0] !== 1'b0 || txdV[0] !== 1'b1) bad++;
            @(negedge clk);
        end
        checkOutput("zeroBytes_quiet", bad, 0);

        // Start during a transfer is ignored; start right after done begins at once.
        buildModel(0, 64'h1122334455667788, 8);
        applyStimulus(0, 64'h1122334455667788, 8);
        observe(0, 300, 64'hDEADBEEFCAFEF00D, te, be, de, bc);
        checkRun("busyStart", 800, te, be, de, bc);
        buildModel(0, 64'h000000000000F00F, 2);
        applyStimulus(0, 64'h000000000000F00F, 2);
        observe(0, -1, 64'h0, te, be, de, bc);
        checkRun("chained", 200, te, be, de, bc);
        settle(0, "chained");

        // Reset mid-frame abandons the transfer.
        applyStimulus(0, 64'h000000000000A55A, 2);
        repeat (45) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset_txd", txdV[0], 1);
        checkOutput("midReset_busy", busyV[0], 0);
        checkOutput("midReset_done", doneV[0], 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            if (busyV[0] !== 1'b0 || doneV[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        checkOutput("midReset_quiet", bad, 0);
        runVector("afterReset", vecs[5]);

        for (int r = 0; r < 12; r++) begin
            idx   = int'($urandom_range(0, NDUT - 1));
            data  = {$urandom, $urandom};
            bytes = int'($urandom_range(1, 15));
            buildModel(idx, data, bytes);
            applyStimulus(idx, data, bytes);
            observe(idx, -1, 64'h0, te, be, de, bc);
            checkRun($sformatf("rand%0d_dut%0d_n%0d", r, idx, bytes), expWave.size(),
                     te, be, de, bc);
            settle(idx, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
